// File: rtl/store_write_buffer_if.sv
// store_write_buffer_if
//   Bundles the store-queue lanes, the dcache write handshake and the load
//   forwarding lookup of the store write buffer.
//   slave  modport : the buffer itself
//   master modport : store queue / dcache / load path environment
//   sq_dcache_packet : NUM_SQ_DCACHE x {valid, addr, sign_size, data}, lane 0 oldest
//   dcache_accept    : per-lane accept, in-order prefix
//   wr_*             : head entry write to the dcache (valid/ready)
//   ld_addr/fwd_*    : byte-granular forwarding lookup
//   empty            : buffer holds no entries
`timescale 1ns/1ps
`ifndef NUM_SQ_DCACHE
`define NUM_SQ_DCACHE 2
`endif

interface store_write_buffer_if #(
  parameter int unsigned NUM_SQ_DCACHE = `NUM_SQ_DCACHE
);
  // sign_size = {sign, size[1:0]}; size 0 = byte, 1 = half, 2/3 = word
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  sign_size;
    logic [31:0] data;
  } sq_dcache_packet_t;

  sq_dcache_packet_t [NUM_SQ_DCACHE-1:0] sq_dcache_packet;
  logic [NUM_SQ_DCACHE-1:0]              dcache_accept;
  logic                                  wr_valid;
  logic [31:0]                           wr_addr;
  logic [31:0]                           wr_data;
  logic [3:0]                            wr_byte_en;
  logic                                  wr_ready;
  logic [31:0]                           ld_addr;
  logic [31:0]                           fwd_data;
  logic [3:0]                            fwd_mask;
  logic                                  empty;

  modport slave (
    input  sq_dcache_packet,
    output dcache_accept,
    output wr_valid, wr_addr, wr_data, wr_byte_en,
    input  wr_ready,
    input  ld_addr,
    output fwd_data, fwd_mask,
    output empty
  );

  modport master (
    output sq_dcache_packet,
    input  dcache_accept,
    input  wr_valid, wr_addr, wr_data, wr_byte_en,
    output wr_ready,
    output ld_addr,
    input  fwd_data, fwd_mask,
    input  empty
  );
endinterface

// File: rtl/store_write_buffer.sv
// store_write_buffer
//   Post-commit store buffer between the store queue and the dcache write port.
//   Accepts up to NUM_SQ_DCACHE stores per cycle (in-order prefix), merges a
//   store into the youngest non-head entry on a word match, drains one entry
//   per cycle and offers a combinational byte-granular forwarding lookup.
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : store_write_buffer_if.slave (lanes, accept, wr_*, ld/fwd, empty)
`timescale 1ns/1ps
`ifndef NUM_SQ_DCACHE
`define NUM_SQ_DCACHE 2
`endif

module store_write_buffer #(
  parameter int unsigned NUM_SQ_DCACHE = `NUM_SQ_DCACHE,
  parameter int unsigned SWB_DEPTH     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  store_write_buffer_if.slave  bus
);
  localparam int unsigned IW = (SWB_DEPTH > 1) ? $clog2(SWB_DEPTH) : 1;
  localparam int unsigned CW = $clog2(SWB_DEPTH + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  logic [29:0] addr_q [SWB_DEPTH];
  logic [29:0] addr_d [SWB_DEPTH];
  logic [31:0] data_q [SWB_DEPTH];
  logic [31:0] data_d [SWB_DEPTH];
  logic [3:0]  be_q   [SWB_DEPTH];
  logic [3:0]  be_d   [SWB_DEPTH];
  idx_t        head_q, head_d;
  idx_t        tail_q, tail_d;
  cnt_t        count_q, count_d;

  logic [NUM_SQ_DCACHE-1:0] accept;
  logic        pop;
  logic        blocked;
  logic        y_valid;
  idx_t        y_idx;
  cnt_t        free_slots;
  cnt_t        n_alloc;
  logic [29:0] l_word;
  logic [3:0]  l_be;
  logic [31:0] l_data;
  logic [31:0] fwd_data_c;
  logic [3:0]  fwd_mask_c;
  idx_t        fwd_ptr;
  logic        unused_bits;

  function automatic idx_t wrap_inc(input idx_t i);
    return (i == idx_t'(SWB_DEPTH - 1)) ? '0 : i + idx_t'(1);
  endfunction

  // Returns {byte_en, lane-aligned data}; the sign bit plays no role here.
  function automatic logic [35:0] lane_fmt(input logic [1:0] off,
                                           input logic [1:0] size,
                                           input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] dat;
    case (size)
      2'b00: begin
        be  = 4'b0001 << off;
        dat = {24'b0, d[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        be  = off[1] ? 4'b1100 : 4'b0011;
        dat = off[1] ? {d[15:0], 16'b0} : {16'b0, d[15:0]};
      end
      default: begin
        be  = 4'hF;
        dat = d;
      end
    endcase
    return {be, dat};
  endfunction

  // Lanes are walked oldest first; y_idx tracks the youngest entry including
  // ones allocated by lower lanes this cycle, so a later lane can merge into it.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    be_d       = be_q;
    head_d     = head_q;
    tail_d     = tail_q;
    accept     = '0;
    blocked    = 1'b0;
    n_alloc    = '0;
    l_word     = '0;
    l_be       = '0;
    l_data     = '0;
    pop        = (count_q != '0) && bus.wr_ready;
    free_slots = cnt_t'(SWB_DEPTH) - count_q;
    y_valid    = (count_q != '0);
    y_idx      = (tail_q == '0) ? idx_t'(SWB_DEPTH - 1) : tail_q - idx_t'(1);

    for (int unsigned i = 0; i < NUM_SQ_DCACHE; i++) begin
      l_word         = bus.sq_dcache_packet[i].addr[31:2];
      {l_be, l_data} = lane_fmt(bus.sq_dcache_packet[i].addr[1:0],
                                bus.sq_dcache_packet[i].sign_size[1:0],
                                bus.sq_dcache_packet[i].data);
      if (bus.sq_dcache_packet[i].valid && !blocked && reset) begin
        if (y_valid && (addr_d[y_idx] == l_word) && (y_idx != head_q)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (l_be[b]) data_d[y_idx][8*b +: 8] = l_data[8*b +: 8];
          end
          be_d[y_idx] = be_d[y_idx] | l_be;
          accept[i]   = 1'b1;
        end else if (free_slots != '0) begin
          addr_d[tail_d] = l_word;
          data_d[tail_d] = l_data;
          be_d[tail_d]   = l_be;
          y_idx          = tail_d;
          y_valid        = 1'b1;
          tail_d         = wrap_inc(tail_d);
          free_slots     = free_slots - cnt_t'(1);
          n_alloc        = n_alloc + cnt_t'(1);
          accept[i]      = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end

    if (pop) head_d = wrap_inc(head_q);
    count_d = count_q + n_alloc - cnt_t'(pop);
  end

  // Walk oldest to youngest so the youngest matching byte overwrites older ones.
  always_comb begin
    fwd_data_c = '0;
    fwd_mask_c = '0;
    fwd_ptr    = head_q;
    for (int unsigned k = 0; k < SWB_DEPTH; k++) begin
      if ((k < 32'(count_q)) && (addr_q[fwd_ptr] == bus.ld_addr[31:2])) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_q[fwd_ptr][b]) begin
            fwd_data_c[8*b +: 8] = data_q[fwd_ptr][8*b +: 8];
            fwd_mask_c[b]        = 1'b1;
          end
        end
      end
      fwd_ptr = wrap_inc(fwd_ptr);
    end
  end

  always_comb begin
    unused_bits = ^bus.ld_addr[1:0];
    for (int unsigned i = 0; i < NUM_SQ_DCACHE; i++) begin
      unused_bits = unused_bits ^ bus.sq_dcache_packet[i].sign_size[2];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned e = 0; e < SWB_DEPTH; e++) begin
        addr_q[e] <= '0;
        data_q[e] <= '0;
        be_q[e]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int unsigned e = 0; e < SWB_DEPTH; e++) begin
        addr_q[e] <= addr_d[e];
        data_q[e] <= data_d[e];
        be_q[e]   <= be_d[e];
      end
    end
  end

  assign bus.dcache_accept = accept;
  assign bus.wr_valid      = (count_q != '0);
  assign bus.wr_addr       = {addr_q[head_q], 2'b00};
  assign bus.wr_data       = data_q[head_q];
  assign bus.wr_byte_en    = be_q[head_q];
  assign bus.fwd_data      = fwd_data_c;
  assign bus.fwd_mask      = fwd_mask_c;
  assign bus.empty         = (count_q == '0);

endmodule
